// File: rtl/io_bus_cycle_master.sv
// Queued host commands become PCjr-style IO/memory bus cycles paced by CPU clock strobes.
// One pop clock before the strobe asserts; cmd_ready drops when the FIFO is full, READY=0 stretches a cycle.
module io_bus_cycle_master #(
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cpu_clock_posedge,
   input  logic                  cpu_clock_negedge,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic                  cmd_io,
   input  logic [ADDR_WIDTH-1:0] cmd_address,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  busy,
   input  logic                  READY,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   output logic [ADDR_WIDTH-1:0] ADDRESS,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  X_IO_OR_M,
   output logic                  R_OR_DT,
   output logic                  IOR_N,
   output logic                  IOW_N,
   output logic                  MEMR_N,
   output logic                  MEMW_N,
   output logic                  IO_E
);

   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int CW      = PW + 1;
   localparam int NEG_END = 2 + WAIT_STATES;
   localparam int NW      = $clog2(NEG_END + 1);

   typedef struct packed {
      logic                  write;
      logic                  io;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RECOVER} state_t;

   cmd_t            fifo_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   state_t          state_q, state_d;
   logic            seen_pos_q, seen_pos_d;
   logic [NW-1:0]   neg_cnt_q, neg_cnt_d;
   logic            cur_write_q, cur_write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic            io_q, io_d, rdt_q, rdt_d, ioe_q, ioe_d;
   logic            ior_n_q, ior_n_d, iow_n_q, iow_n_d;
   logic            memr_n_q, memr_n_d, memw_n_q, memw_n_d;
   logic            rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic full, push, pop, pos_eff;
   cmd_t head, push_cmd;

   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign cmd_ready = !reset && !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == S_IDLE) && (count_q != '0);
   assign head      = fifo_q[rd_ptr_q];
   assign push_cmd  = '{write: cmd_write, io: cmd_io, addr: cmd_address, data: cmd_data};
   // A posedge arriving with a negedge in the same clock counts as having come first.
   assign pos_eff   = seen_pos_q || cpu_clock_posedge;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      seen_pos_d  = seen_pos_q;
      neg_cnt_d   = neg_cnt_q;
      cur_write_d = cur_write_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      io_d        = io_q;
      rdt_d       = rdt_q;
      ioe_d       = ioe_q;
      ior_n_d     = ior_n_q;
      iow_n_d     = iow_n_q;
      memr_n_d    = memr_n_q;
      memw_n_d    = memw_n_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d     = S_ACTIVE;
               seen_pos_d  = 1'b0;
               neg_cnt_d   = '0;
               cur_write_d = head.write;
               addr_d      = head.addr;
               dout_d      = head.write ? head.data : '0;
               io_d        = head.io;
               rdt_d       = !head.write;
               ioe_d       = 1'b1;
               ior_n_d     = !( head.io && !head.write);
               iow_n_d     = !( head.io &&  head.write);
               memr_n_d    = !(!head.io && !head.write);
               memw_n_d    = !(!head.io &&  head.write);
            end
         end
         S_ACTIVE: begin
            if (cpu_clock_posedge) seen_pos_d = 1'b1;
            if (cpu_clock_negedge && pos_eff) begin
               if (neg_cnt_q != NW'(NEG_END)) neg_cnt_d = neg_cnt_q + NW'(1);
               if ((neg_cnt_q >= NW'(NEG_END - 1)) && READY) begin
                  state_d     = S_RECOVER;
                  addr_d      = '0;
                  dout_d      = '0;
                  io_d        = 1'b0;
                  rdt_d       = 1'b1;
                  ioe_d       = 1'b0;
                  ior_n_d     = 1'b1;
                  iow_n_d     = 1'b1;
                  memr_n_d    = 1'b1;
                  memw_n_d    = 1'b1;
                  rsp_valid_d = 1'b1;
                  rsp_write_d = cur_write_q;
                  if (!cur_write_q) rsp_data_d = DATA_IN;
               end
            end
         end
         S_RECOVER: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) fifo_q[wr_ptr_q] <= push_cmd;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         seen_pos_q  <= 1'b0;
         neg_cnt_q   <= '0;
         cur_write_q <= 1'b0;
         addr_q      <= '0;
         dout_q      <= '0;
         io_q        <= 1'b0;
         rdt_q       <= 1'b1;
         ioe_q       <= 1'b0;
         ior_n_q     <= 1'b1;
         iow_n_q     <= 1'b1;
         memr_n_q    <= 1'b1;
         memw_n_q    <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q     <= count_d;
         state_q     <= state_d;
         seen_pos_q  <= seen_pos_d;
         neg_cnt_q   <= neg_cnt_d;
         cur_write_q <= cur_write_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         io_q        <= io_d;
         rdt_q       <= rdt_d;
         ioe_q       <= ioe_d;
         ior_n_q     <= ior_n_d;
         iow_n_q     <= iow_n_d;
         memr_n_q    <= memr_n_d;
         memw_n_q    <= memw_n_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign busy      = (count_q != '0) || (state_q == S_ACTIVE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_data  = rsp_data_q;
   assign ADDRESS   = addr_q;
   assign DATA_OUT  = dout_q;
   assign X_IO_OR_M = io_q;
   assign R_OR_DT   = rdt_q;
   assign IOR_N     = ior_n_q;
   assign IOW_N     = iow_n_q;
   assign MEMR_N    = memr_n_q;
   assign MEMW_N    = memw_n_q;
   assign IO_E      = ioe_q;

endmodule

// File: tb/tb_io_bus_cycle_master.sv
// Randomised and directed bench for io_bus_cycle_master against a queue-based transaction model.
module tb_io_bus_cycle_master;
   localparam int AW = 20, DW = 8, DEPTH = 4, WS = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset, cpu_clock_posedge, cpu_clock_negedge, cmd_valid, cmd_write, cmd_io, READY;
   logic [AW-1:0] cmd_address;
   logic [DW-1:0] cmd_data, DATA_IN;
   wire cmd_ready, rsp_valid, rsp_write, busy, X_IO_OR_M, R_OR_DT, IOR_N, IOW_N, MEMR_N, MEMW_N, IO_E;
   wire [DW-1:0] rsp_data, DATA_OUT;
   wire [AW-1:0] ADDRESS;

   io_bus_cycle_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .clock(clock), .reset(reset), .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_io(cmd_io),
      .cmd_address(cmd_address), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_write(rsp_write),
      .rsp_data(rsp_data), .busy(busy), .READY(READY), .DATA_IN(DATA_IN), .ADDRESS(ADDRESS),
      .DATA_OUT(DATA_OUT), .X_IO_OR_M(X_IO_OR_M), .R_OR_DT(R_OR_DT), .IOR_N(IOR_N), .IOW_N(IOW_N),
      .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IO_E(IO_E));

   typedef struct {bit w; bit io; bit [AW-1:0] a; bit [DW-1:0] d;} cmd_t;
   cmd_t mq[$];
   cmd_t cur;
   int   m_mode;      // 0 nothing on bus, 1 cycle on bus, 2 response clock
   bit   m_seen;
   int   m_negs;
   bit [DW-1:0] m_rdata;
   bit   m_rwrite;

   int n_chk = 0, n_pass = 0;
   int cc = 0, smode = 0, hold_mode = 0, n_acc = 0;
   bit tr_seen = 0;
   int tr_negs = 0, last_negs = 0, idle_run = 0, last_gap = 0, got = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic compare_all();
      bit on;
      on = (m_mode == 1);
      chk("cmd_ready", 32'(cmd_ready), 32'(!reset && mq.size() < DEPTH));
      chk("ADDRESS",   32'(ADDRESS),   on ? 32'(cur.a) : 32'd0);
      chk("DATA_OUT",  32'(DATA_OUT),  (on && cur.w) ? 32'(cur.d) : 32'd0);
      chk("X_IO_OR_M", 32'(X_IO_OR_M), 32'(on && cur.io));
      chk("R_OR_DT",   32'(R_OR_DT),   32'(!(on && cur.w)));
      chk("IOR_N",     32'(IOR_N),     32'(!(on && cur.io && !cur.w)));
      chk("IOW_N",     32'(IOW_N),     32'(!(on && cur.io && cur.w)));
      chk("MEMR_N",    32'(MEMR_N),    32'(!(on && !cur.io && !cur.w)));
      chk("MEMW_N",    32'(MEMW_N),    32'(!(on && !cur.io && cur.w)));
      chk("IO_E",      32'(IO_E),      32'(on));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_mode == 2));
      chk("rsp_write", 32'(rsp_write), 32'(m_rwrite));
      chk("rsp_data",  32'(rsp_data),  32'(m_rdata));
      chk("busy",      32'(busy),      32'(mq.size() != 0 || on));
   endtask

   task automatic model_step();
      bit acc;
      cmd_t c;
      if (reset) begin
         mq.delete(); m_mode = 0; m_rdata = '0; m_rwrite = 0;
         return;
      end
      acc = cmd_valid && (mq.size() < DEPTH);
      case (m_mode)
         0: if (mq.size() > 0) begin
               cur = mq.pop_front(); m_mode = 1; m_seen = 0; m_negs = 0;
            end
         1: begin
               if (cpu_clock_posedge) m_seen = 1;
               if (cpu_clock_negedge && m_seen) begin
                  m_negs++;
                  if (m_negs >= 2 + WS && READY) begin
                     m_mode = 2; m_rwrite = cur.w;
                     if (!cur.w) m_rdata = DATA_IN;
                  end
               end
            end
         default: m_mode = 0;
      endcase
      if (acc) begin
         c.w = cmd_write; c.io = cmd_io; c.a = cmd_address; c.d = cmd_data;
         mq.push_back(c);
      end
   endtask

   task automatic tick();
      bit low;
      int r, idx;
      if (smode == 0) begin
         cpu_clock_posedge = (cc % 4 == 0);
         cpu_clock_negedge = (cc % 4 == 2);
      end else begin
         r = $urandom_range(0, 9);
         cpu_clock_posedge = (r < 3) || (r == 9);
         cpu_clock_negedge = (r >= 3 && r < 6) || (r == 9);
      end
      cc++;
      low = !(IOR_N && IOW_N && MEMR_N && MEMW_N);
      if (hold_mode != 0) begin
         idx = tr_negs + 1;
         READY = !(low && cpu_clock_negedge && (tr_seen || cpu_clock_posedge) && (idx == 4 || idx == 5));
      end
      #1;
      compare_all();
      if (cmd_valid && cmd_ready) n_acc++;
      if (!low) begin
         tr_seen = 0; tr_negs = 0; idle_run++;
      end else begin
         if (idle_run > 0) last_gap = idle_run;
         idle_run = 0;
         if (cpu_clock_posedge) tr_seen = 1;
         if (cpu_clock_negedge && tr_seen) tr_negs++;
         last_negs = tr_negs;
      end
      model_step();
      @(posedge clock); #1;
   endtask

   task automatic push(input bit w, input bit io, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid = 1; cmd_write = w; cmd_io = io; cmd_address = a; cmd_data = d;
      tick();
      cmd_valid = 0;
   endtask

   task automatic wait_rsp(input int n, input int budget);
      got = 0;
      for (int i = 0; i < budget && got < n; i++) begin
         tick();
         if (rsp_valid) got++;
      end
   endtask

   initial begin
      reset = 1; cpu_clock_posedge = 0; cpu_clock_negedge = 0; cmd_valid = 0; cmd_write = 0;
      cmd_io = 0; cmd_address = '0; cmd_data = '0; READY = 1; DATA_IN = '0;
      m_mode = 0; m_seen = 0; m_negs = 0; m_rdata = '0; m_rwrite = 0;
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_strobes", 32'({IOR_N, IOW_N, MEMR_N, MEMW_N, R_OR_DT, IO_E}), 32'h3E);
      reset = 0;
      tick();
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // IO read
      DATA_IN = 8'h5A;
      push(0, 1, 20'h00040, 8'h00);
      wait_rsp(1, 200);
      chk("ior_rsp_count", 32'(got), 32'd1);
      chk("ior_rsp_data", 32'(rsp_data), 32'h5A);
      chk("ior_negs", 32'(last_negs), 32'd4);

      // IO write
      DATA_IN = 8'hFF;
      push(1, 1, 20'h00040, 8'h55);
      wait_rsp(1, 200);
      chk("iow_rsp_count", 32'(got), 32'd1);
      chk("iow_rsp_write", 32'(rsp_write), 32'd1);
      chk("iow_rsp_data_held", 32'(rsp_data), 32'h5A);
      chk("iow_negs", 32'(last_negs), 32'd4);

      // FIFO full with the bus held
      READY = 0; n_acc = 0;
      cmd_valid = 1; cmd_write = 0; cmd_io = 1; DATA_IN = 8'h33;
      for (int i = 0; i < 6; i++) begin
         cmd_address = 20'h00100 + 20'(i);
         tick();
      end
      cmd_valid = 0;
      chk("full_accepted", 32'(n_acc), 32'd5);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      READY = 1;
      wait_rsp(5, 1000);
      chk("full_rsp_count", 32'(got), 32'd5);

      // wait states with READY dropped on negedges 4 and 5
      hold_mode = 1;
      push(1, 0, 20'h00200, 8'h77);
      wait_rsp(1, 300);
      hold_mode = 0; READY = 1;
      chk("ws_rsp_count", 32'(got), 32'd1);
      chk("ws_end_neg", 32'(last_negs), 32'd6);

      // reset during an active cycle with commands queued
      READY = 0;
      push(0, 1, 20'h00300, 8'h00);
      push(1, 1, 20'h00301, 8'h11);
      push(0, 0, 20'h00302, 8'h00);
      for (int i = 0; i < 4; i++) tick();
      chk("pre_rst_io_e", 32'(IO_E), 32'd1);
      reset = 1;
      tick();
      reset = 0;
      chk("midrst_strobes", 32'({IOR_N, IOW_N, MEMR_N, MEMW_N, IO_E}), 32'h1E);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      READY = 1;
      for (int i = 0; i < 3; i++) tick();
      chk("midrst_fifo_empty", 32'(busy), 32'd0);

      // memory read then write back to back
      DATA_IN = 8'hC3; last_gap = 0;
      push(0, 0, 20'h12345, 8'h00);
      push(1, 0, 20'h12345, 8'hA5);
      wait_rsp(2, 400);
      chk("b2b_rsp_count", 32'(got), 32'd2);
      chk("b2b_gap", 32'(last_gap), 32'd2);
      chk("b2b_rsp_data", 32'(rsp_data), 32'hC3);

      // randomised traffic
      smode = 1;
      for (int i = 0; i < 3000; i++) begin
         cmd_valid   = ($urandom_range(0, 2) == 0);
         cmd_write   = 1'($urandom);
         cmd_io      = 1'($urandom);
         cmd_address = AW'($urandom);
         cmd_data    = DW'($urandom);
         DATA_IN     = DW'($urandom);
         READY       = ($urandom_range(0, 4) != 0);
         reset       = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 0; cmd_valid = 0; READY = 1;
      for (int i = 0; i < 600 && busy; i++) tick();
      chk("drain_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/io_bus_cycle_master.md
Name: io_bus_cycle_master

Overview:
- Parametrised RTL bus master that turns queued host commands into CPU-style IO/memory bus cycles on the PCjr peripheral bus: ADDRESS, DATA_OUT, X_IO_OR_M, R_OR_DT, IOR_N/IOW_N/MEMR_N/MEMW_N and IO_E.
- Cycles are paced by the cpu_clock_posedge/cpu_clock_negedge strobes.
- It is the synthesizable, generalised successor of the fixed read/write cycle sequence used to exercise PERIPHERALS: configurable widths, command FIFO depth, wait states and READY extension.
- Sits between a debug/DMA host port and the peripheral bus.

Parameters:
- ADDR_WIDTH, 20, width of cmd_address and ADDRESS.
- DATA_WIDTH, 8, width of data paths.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- WAIT_STATES, 0, extra cpu_clock_negedge strobes appended to every cycle.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_clock_posedge  in  1  one-clock strobe, CPU clock rising phase.
- cpu_clock_negedge  in  1  one-clock strobe, CPU clock falling phase.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_io  in  1  1 = IO space, 0 = memory space.
- cmd_address  in  ADDR_WIDTH  target address.
- cmd_data  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-clock pulse: a bus cycle completed.
- rsp_write  out  1  type of the completed cycle.
- rsp_data  out  DATA_WIDTH  read data; held until the next rsp_valid.
- busy  out  1  FIFO non-empty or bus cycle in progress.
- READY  in  1  target ready; 0 extends the cycle.
- DATA_IN  in  DATA_WIDTH  bus read data.
- ADDRESS  out  ADDR_WIDTH  bus address.
- DATA_OUT  out  DATA_WIDTH  bus write data.
- X_IO_OR_M, R_OR_DT, IOR_N, IOW_N, MEMR_N, MEMW_N, IO_E  out  1 each  bus control.

Behaviour:
- **Reset values:** ADDRESS=0, DATA_OUT=0, X_IO_OR_M=0, R_OR_DT=1, all *_N=1, IO_E=0, cmd_ready=0 during reset (1 after), rsp_valid=0, rsp_write=0, rsp_data=0, busy=0.
- **Reset mid-operation:** FIFO flushed, bus returns to idle values on the next clock, no rsp_valid issued.
- **FIFO:**
  - A push occurs when cmd_valid and cmd_ready are both high.
  - cmd_ready = !full, computed from the registered count (count width clog2(FIFO_DEPTH)+1). A push and a pop in the same clock while full: the push is refused.
  - A push and a pop in the same clock while non-full: the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **State machine:** IDLE, ACTIVE, RECOVER.
- **IDLE:**
  - If the FIFO is non-empty, pop the head and go to ACTIVE on the next clock.
  - Bus outputs are registered. On ACTIVE entry: ADDRESS, X_IO_OR_M=cmd_io, R_OR_DT=!cmd_write, DATA_OUT=cmd_data (write) or 0 (read), IO_E=1, and exactly one strobe low:
    - IOR_N for IO read
    - IOW_N for IO write
    - MEMR_N for memory read
    - MEMW_N for memory write
- **ACTIVE:**
  - cpu_clock_negedge strobes before the first cpu_clock_posedge are ignored.
  - After that first posedge, count negedges. The cycle is eligible to end at negedge number 2+WAIT_STATES.
  - It ends on the first eligible negedge with READY=1. If READY=0, it waits for a later negedge with READY=1; there is no timeout.
  - For reads, DATA_IN is captured on the ending negedge clock.
  - The posedge and negedge strobes are never asserted in the same clock; if they are, the posedge is processed first.
- **RECOVER:**
  - Lasts exactly one clock. All bus outputs are at idle values, rsp_valid=1, rsp_write=cycle type, and rsp_data is updated for reads only.
  - Then go to IDLE, which may start the next cycle on the following clock. Minimum gap between cycles: 1 idle clock plus the IDLE pop clock.
- **Write ordering:** commands complete strictly in FIFO order.
- **busy:** high from the first pushed command until RECOVER of the last queued command.

Test Plan:
- **Single IO read:** push read, cmd_io=1, 0x00040; DATA_IN=0x5A; strobes alternate every 2 clocks.
  - IOR_N low, IO_E=1, ADDRESS=0x00040 from ACTIVE entry through the 2nd negedge.
  - rsp_valid one pulse with rsp_data=0x5A, then bus idle.
- **IO write:** push write 0x00040 data 0x55.
  - IOW_N low, R_OR_DT=0, DATA_OUT=0x55 for 2 negedges.
  - rsp_valid with rsp_write=1; rsp_data unchanged.
- **FIFO full:** with FIFO_DEPTH=4, hold the bus with READY=0 and push 6 commands.
  - First command popped, next 4 accepted, then cmd_ready=0 and the 6th command refused.
  - After READY=1, all 5 accepted commands complete in order.
- **Wait states:** WAIT_STATES=2 → the strobe stays low for 4 negedges. READY=0 on negedges 4–5 → the cycle ends at negedge 6.
- **Reset mid-cycle:** assert reset during ACTIVE with 2 commands queued.
  - Next clock: all *_N=1, IO_E=0, busy=0, no rsp_valid; FIFO empty after reset.
- **Memory space and back-to-back:** push mem read 0x12345 then mem write 0x12345/0xA5.
  - MEMR_N then MEMW_N, X_IO_OR_M=0, with at least 1 idle clock between the cycles.
